// File: rtl/cmp_meter_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : cmp_meter_pkg
//  Description : Shared types and default constants for the comparator
//                frequency meter (FSM state encoding, default widths).
//  Revision    : 1.0 - initial release
// ============================================================================
package cmp_meter_pkg;

    // Default edge-counter width, window-length width and reset hold time
    localparam int c_CNT_W      = 16;
    localparam int c_GATE_W     = 16;
    localparam int c_RST_CYCLES = 4;

    // Width of the upstream-reset hold counter; covers hold times 1..15
    localparam int c_RST_CNT_W  = 4;

    // Measurement sequencer states
    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        RST_DIG = 2'd1,
        MEASURE = 2'd2,
        DONE    = 2'd3
    } meter_state_t;

endpackage : cmp_meter_pkg
`default_nettype wire

// File: rtl/cmp_sync_edge.sv
`default_nettype none
// ============================================================================
//  Module      : cmp_sync_edge
//  Description : Two-flop synchroniser for the asynchronous comparator output
//                plus an edge-detect flop; o_edge is a one-cycle pulse per
//                synchronised rising edge.
//  Revision    : 1.0 - initial release
// ============================================================================
module cmp_sync_edge
    import cmp_meter_pkg::*;
(
    input  logic clk,
    input  logic rst_n,
    input  logic i_cmp,
    output logic o_edge
);

    logic r_s1;
    logic r_s2;
    logic r_s3;

    // Metastability filter (s1, s2) followed by the delayed copy for edge detect
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_s1 <= 1'b0;
            r_s2 <= 1'b0;
            r_s3 <= 1'b0;
        end else begin
            r_s1 <= i_cmp;
            r_s2 <= r_s1;
            r_s3 <= r_s2;
        end
    end

    // Rising edge of the synchronised comparator signal
    assign o_edge = r_s2 & ~r_s3;

endmodule : cmp_sync_edge
`default_nettype wire

// File: rtl/cmp_freq_meter.sv
`default_nettype none
// ============================================================================
//  Module      : cmp_freq_meter
//  Description : Counts rising edges of an asynchronous comparator output over
//                a programmable window of clk cycles. Holds the upstream stage
//                in reset before each window, publishes the count with a
//                one-cycle valid strobe and a saturation flag. Supports
//                single-shot and continuous operation.
//  Revision    : 1.0 - initial release
// ============================================================================
module cmp_freq_meter
    import cmp_meter_pkg::*;
#(
    parameter int CNT_W      = c_CNT_W,
    parameter int GATE_W     = c_GATE_W,
    parameter int RST_CYCLES = c_RST_CYCLES
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              cmp,
    input  logic              start,
    input  logic              continuous,
    input  logic [GATE_W-1:0] gate_len,
    output logic              dig_rst,
    output logic              busy,
    output logic [CNT_W-1:0]  count,
    output logic              overflow,
    output logic              valid
);

    localparam logic [c_RST_CNT_W-1:0] c_RST_LOAD = c_RST_CNT_W'(RST_CYCLES);
    localparam logic [c_RST_CNT_W-1:0] c_RST_ONE  = c_RST_CNT_W'(1);
    localparam logic [GATE_W-1:0]      c_GATE_ONE = GATE_W'(1);
    localparam logic [CNT_W-1:0]       c_CNT_ONE  = CNT_W'(1);
    localparam logic [CNT_W-1:0]       c_CNT_MAX  = {CNT_W{1'b1}};

    meter_state_t           r_state;
    meter_state_t           w_state_nxt;
    logic                   w_edge;
    logic                   w_arm_new;
    logic                   w_arm;
    logic                   w_last;
    logic [GATE_W-1:0]      r_gate_len;
    logic [GATE_W-1:0]      r_gate_cnt;
    logic [c_RST_CNT_W-1:0] r_rst_cnt;
    logic [CNT_W-1:0]       r_edge_cnt;
    logic [CNT_W-1:0]       w_edge_cnt_nxt;
    logic                   r_ovf;
    logic                   w_ovf_nxt;

    cmp_sync_edge u_sync (
        .clk    (clk),
        .rst_n  (rst_n),
        .i_cmp  (cmp),
        .o_edge (w_edge)
    );

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next-state decode; w_arm marks entry into RST_DIG (new start or re-arm)
    always_comb begin
        w_state_nxt = r_state;
        w_arm_new   = 1'b0;
        w_arm       = 1'b0;
        w_last      = 1'b0;
        case (r_state)
            IDLE: begin
                if (start) begin
                    w_state_nxt = RST_DIG;
                    w_arm_new   = 1'b1;
                    w_arm       = 1'b1;
                end
            end
            RST_DIG: begin
                if (r_rst_cnt == c_RST_ONE) begin
                    w_state_nxt = MEASURE;
                end
            end
            MEASURE: begin
                if (r_gate_cnt == c_GATE_ONE) begin
                    w_state_nxt = DONE;
                    w_last      = 1'b1;
                end
            end
            DONE: begin
                if (continuous) begin
                    w_state_nxt = RST_DIG;
                    w_arm       = 1'b1;
                end else begin
                    w_state_nxt = IDLE;
                end
            end
            default: begin
                w_state_nxt = IDLE;
            end
        endcase
    end

    // Saturating edge count; an edge that finds the counter full flags overflow
    always_comb begin
        w_edge_cnt_nxt = r_edge_cnt;
        w_ovf_nxt      = r_ovf;
        if (w_edge) begin
            if (r_edge_cnt == c_CNT_MAX) begin
                w_ovf_nxt = 1'b1;
            end else begin
                w_edge_cnt_nxt = r_edge_cnt + c_CNT_ONE;
            end
        end
    end

    // Window/reset counters, edge accumulator and result registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_gate_len <= '0;
            r_gate_cnt <= '0;
            r_rst_cnt  <= '0;
            r_edge_cnt <= '0;
            r_ovf      <= 1'b0;
            count      <= '0;
            overflow   <= 1'b0;
        end else begin
            // A zero-length window is stretched to one cycle
            if (w_arm_new) begin
                r_gate_len <= (gate_len == '0) ? c_GATE_ONE : gate_len;
            end
            if (w_arm) begin
                r_rst_cnt  <= c_RST_LOAD;
                r_edge_cnt <= '0;
                r_ovf      <= 1'b0;
            end
            if (r_state == RST_DIG) begin
                if (r_rst_cnt == c_RST_ONE) begin
                    r_gate_cnt <= r_gate_len;
                end else begin
                    r_rst_cnt <= r_rst_cnt - c_RST_ONE;
                end
            end
            if (r_state == MEASURE) begin
                r_edge_cnt <= w_edge_cnt_nxt;
                r_ovf      <= w_ovf_nxt;
                r_gate_cnt <= r_gate_cnt - c_GATE_ONE;
                // The final cycle's edge is folded into the published result
                if (w_last) begin
                    count    <= w_edge_cnt_nxt;
                    overflow <= w_ovf_nxt;
                end
            end
        end
    end

    // Status outputs registered from the next state so they line up with it
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            dig_rst <= 1'b1;
            busy    <= 1'b0;
            valid   <= 1'b0;
        end else begin
            dig_rst <= (w_state_nxt == IDLE) || (w_state_nxt == RST_DIG);
            busy    <= (w_state_nxt != IDLE);
            valid   <= (w_state_nxt == DONE);
        end
    end

endmodule : cmp_freq_meter
`default_nettype wire

// File: tb/tb_cmp_freq_meter.sv
`default_nettype none
// ============================================================================
//  Module      : tb_cmp_freq_meter
//  Description : Directed self-checking bench for cmp_freq_meter. A second
//                instance with a 4-bit counter exercises saturation.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_cmp_freq_meter;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        cmp = 1'b0;
    logic        start = 1'b0;
    logic        continuous = 1'b0;
    logic [15:0] gate_len = 16'd0;

    logic        dig_rst, busy, overflow, valid;
    logic [15:0] count;
    logic        dig_rst_b, busy_b, overflow_b, valid_b;
    logic [3:0]  count_b;

    int n_vec = 0;
    int n_err = 0;
    int sq_half = 0;
    int sq_phase = 0;

    cmp_freq_meter #(.CNT_W(16), .GATE_W(16), .RST_CYCLES(4)) u_dut (
        .clk(clk), .rst_n(rst_n), .cmp(cmp), .start(start), .continuous(continuous),
        .gate_len(gate_len), .dig_rst(dig_rst), .busy(busy), .count(count),
        .overflow(overflow), .valid(valid)
    );

    cmp_freq_meter #(.CNT_W(4), .GATE_W(16), .RST_CYCLES(4)) u_dut_ovf (
        .clk(clk), .rst_n(rst_n), .cmp(cmp), .start(start), .continuous(continuous),
        .gate_len(gate_len), .dig_rst(dig_rst_b), .busy(busy_b), .count(count_b),
        .overflow(overflow_b), .valid(valid_b)
    );

    always #5 clk = ~clk;

    // One clock; returns 1 time unit after the rising edge, advances square wave
    task automatic tick();
        @(posedge clk);
        #1;
        if (sq_half != 0) begin
            sq_phase++;
            cmp = ((sq_phase / sq_half) % 2) == 1;
        end
    endtask

    // Runs one single-shot window. d counts clocks after start is driven.
    // half=0 drives cmp from mask[d]; otherwise square wave of period 2*half.
    task automatic run_window(input int g, input logic [63:0] mask, input int half,
                              input int poke_d, output int vd, output int nlow);
        int d;
        sq_half = 0;
        cmp = 1'b0;
        tick();
        tick();
        gate_len = 16'(g);
        sq_half  = half;
        sq_phase = 0;
        start    = 1'b1;
        vd = -1;
        nlow = 0;
        d = 0;
        while (vd < 0 && d < 400) begin
            tick();
            d++;
            start = 1'b0;
            if (d == poke_d) begin
                start    = 1'b1;
                gate_len = 16'd200;
            end
            if (half == 0) cmp = (d < 64) ? mask[d] : 1'b0;
            if (valid) vd = d;
            else if (!dig_rst) nlow++;
        end
        sq_half = 0;
        cmp = 1'b0;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        n_vec++; if (dig_rst !== 1'b1) begin n_err++; $display("FAIL reset_dig_rst: got %b want 1", dig_rst); end
        n_vec++; if (busy !== 1'b0) begin n_err++; $display("FAIL reset_busy: got %b want 0", busy); end
        n_vec++; if (count !== 16'd0) begin n_err++; $display("FAIL reset_count: got %0d want 0", count); end
        n_vec++; if (overflow !== 1'b0) begin n_err++; $display("FAIL reset_overflow: got %b want 0", overflow); end
        n_vec++; if (valid !== 1'b0) begin n_err++; $display("FAIL reset_valid: got %b want 0", valid); end
        n_vec++; if ({dig_rst_b, busy_b, count_b} !== 6'b1_0_0000) begin n_err++; $display("FAIL reset_ovf_inst: got %b want 100000", {dig_rst_b, busy_b, count_b}); end
        rst_n = 1'b1;
        tick();
    endtask

    task automatic test_single_shot();
        int vd, nlow;
        run_window(100, 64'h0, 5, -1, vd, nlow);
        n_vec++; if (vd !== 105) begin n_err++; $display("FAIL single_valid_cycle: got %0d want 105", vd); end
        n_vec++; if (nlow !== 100) begin n_err++; $display("FAIL single_dig_rst_low: got %0d want 100", nlow); end
        n_vec++; if (count !== 16'd10) begin n_err++; $display("FAIL single_count: got %0d want 10", count); end
        n_vec++; if (overflow !== 1'b0) begin n_err++; $display("FAIL single_overflow: got %b want 0", overflow); end
        tick();
        n_vec++; if ({busy, dig_rst, valid} !== 3'b010) begin n_err++; $display("FAIL single_after_done: got busy/dig_rst/valid %b want 010", {busy, dig_rst, valid}); end
    endtask

    task automatic test_boundary();
        int vd, nlow;
        // pulse counted in RST_DIG (ignored) and in last MEASURE cycle
        run_window(6, 64'h104, 0, -1, vd, nlow);
        n_vec++; if (vd !== 11) begin n_err++; $display("FAIL bnd_a_valid_cycle: got %0d want 11", vd); end
        n_vec++; if (count !== 16'd1) begin n_err++; $display("FAIL bnd_rst_and_last: got %0d want 1", count); end
        // pulse in first MEASURE cycle (counted) and in DONE (ignored)
        run_window(6, 64'h208, 0, -1, vd, nlow);
        n_vec++; if (count !== 16'd1) begin n_err++; $display("FAIL bnd_first_and_done: got %0d want 1", count); end
        // first, middle and last cycles
        run_window(6, 64'h128, 0, -1, vd, nlow);
        n_vec++; if (count !== 16'd3) begin n_err++; $display("FAIL bnd_first_mid_last: got %0d want 3", count); end
    endtask

    task automatic test_zero_gate();
        int vd, nlow;
        run_window(0, 64'h8, 0, -1, vd, nlow);
        n_vec++; if (vd !== 6) begin n_err++; $display("FAIL zero_gate_valid_cycle: got %0d want 6", vd); end
        n_vec++; if (nlow !== 1) begin n_err++; $display("FAIL zero_gate_measure_len: got %0d want 1", nlow); end
        n_vec++; if (count !== 16'd1) begin n_err++; $display("FAIL zero_gate_count: got %0d want 1", count); end
    endtask

    task automatic test_ignored_inputs();
        int vd, nlow;
        run_window(30, 64'h0, 5, 12, vd, nlow);
        n_vec++; if (vd !== 35) begin n_err++; $display("FAIL ignore_valid_cycle: got %0d want 35", vd); end
        n_vec++; if (count !== 16'd3) begin n_err++; $display("FAIL ignore_count: got %0d want 3", count); end
        tick();
        tick();
        n_vec++; if (busy !== 1'b0) begin n_err++; $display("FAIL ignore_back_to_idle: got busy %b want 0", busy); end
    endtask

    task automatic test_overflow();
        int vd, nlow;
        run_window(50, 64'h0, 1, -1, vd, nlow);
        n_vec++; if (vd !== 55) begin n_err++; $display("FAIL ovf_valid_cycle: got %0d want 55", vd); end
        n_vec++; if (valid_b !== 1'b1) begin n_err++; $display("FAIL ovf_inst_valid: got %b want 1", valid_b); end
        n_vec++; if (count !== 16'd25) begin n_err++; $display("FAIL ovf_wide_count: got %0d want 25", count); end
        n_vec++; if (overflow !== 1'b0) begin n_err++; $display("FAIL ovf_wide_flag: got %b want 0", overflow); end
        n_vec++; if (count_b !== 4'd15) begin n_err++; $display("FAIL ovf_sat_count: got %0d want 15", count_b); end
        n_vec++; if (overflow_b !== 1'b1) begin n_err++; $display("FAIL ovf_sat_flag: got %b want 1", overflow_b); end
    endtask

    task automatic test_continuous();
        int vt[4];
        logic [15:0] vc[4];
        int nv;
        int drop_d;
        for (int i = 0; i < 4; i++) begin vt[i] = -1000; vc[i] = 16'hFFFF; end
        tick();
        tick();
        gate_len   = 16'd20;
        sq_half    = 5;
        sq_phase   = 0;
        continuous = 1'b1;
        start      = 1'b1;
        nv = 0;
        drop_d = -1;
        for (int d = 1; d <= 140; d++) begin
            tick();
            start = 1'b0;
            if (valid) begin
                if (nv < 4) begin vt[nv] = d; vc[nv] = count; end
                nv++;
            end
            if (nv == 3 && drop_d < 0) drop_d = d + 5;
            if (d == drop_d) continuous = 1'b0;
        end
        sq_half = 0;
        cmp = 1'b0;
        n_vec++; if (nv !== 4) begin n_err++; $display("FAIL cont_num_results: got %0d want 4", nv); end
        n_vec++; if (vt[0] !== 25) begin n_err++; $display("FAIL cont_first_valid: got %0d want 25", vt[0]); end
        n_vec++; if (vt[1] - vt[0] !== 25) begin n_err++; $display("FAIL cont_period_1: got %0d want 25", vt[1] - vt[0]); end
        n_vec++; if (vt[2] - vt[1] !== 25) begin n_err++; $display("FAIL cont_period_2: got %0d want 25", vt[2] - vt[1]); end
        n_vec++; if (vt[3] - vt[2] !== 25) begin n_err++; $display("FAIL cont_period_3: got %0d want 25", vt[3] - vt[2]); end
        n_vec++; if (vc[0] !== 16'd2) begin n_err++; $display("FAIL cont_count_first: got %0d want 2", vc[0]); end
        n_vec++; if (vc[3] !== 16'd2) begin n_err++; $display("FAIL cont_count_last: got %0d want 2", vc[3]); end
        n_vec++; if ({busy, dig_rst} !== 2'b01) begin n_err++; $display("FAIL cont_end_idle: got busy/dig_rst %b want 01", {busy, dig_rst}); end
    endtask

    task automatic test_reset_mid();
        int vd, nlow;
        tick();
        tick();
        gate_len = 16'd100;
        sq_half  = 5;
        sq_phase = 0;
        start    = 1'b1;
        for (int d = 1; d <= 35; d++) begin
            tick();
            start = 1'b0;
        end
        n_vec++; if ({busy, dig_rst} !== 2'b10) begin n_err++; $display("FAIL rstmid_in_window: got busy/dig_rst %b want 10", {busy, dig_rst}); end
        #2 rst_n = 1'b0;
        #1;
        n_vec++; if (count !== 16'd0) begin n_err++; $display("FAIL rstmid_count: got %0d want 0", count); end
        n_vec++; if (valid !== 1'b0) begin n_err++; $display("FAIL rstmid_valid: got %b want 0", valid); end
        n_vec++; if ({busy, dig_rst} !== 2'b01) begin n_err++; $display("FAIL rstmid_idle: got busy/dig_rst %b want 01", {busy, dig_rst}); end
        #2 rst_n = 1'b1;
        run_window(40, 64'h0, 5, -1, vd, nlow);
        n_vec++; if (vd !== 45) begin n_err++; $display("FAIL rstmid_after_valid_cycle: got %0d want 45", vd); end
        n_vec++; if (count !== 16'd4) begin n_err++; $display("FAIL rstmid_after_count: got %0d want 4", count); end
    endtask

    initial begin
        test_reset();
        test_single_shot();
        test_boundary();
        test_zero_gate();
        test_ignored_inputs();
        test_overflow();
        test_continuous();
        test_reset_mid();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule : tb_cmp_freq_meter
`default_nettype wire
